// File: rtl/led_pio_arbiter_pkg.sv
// Shared definitions for the LED PIO arbiter: register offset, FSM states, default width.
package led_pio_arbiter_pkg;

  localparam logic [1:0] DATA_REG       = 2'd0;
  localparam int         DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/led_pio_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request bit after i_last, wrapping around.
module led_pio_arbiter_rr_pick
  import led_pio_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_pos;

  // Scan from the farthest offset down so the nearest candidate after i_last wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = N; k >= 1; k--) begin
      w_pos = IDX_W'((int'(i_last) + k) % N);
      if (i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Round-robin arbiter sharing one LED PIO slave: grant, write, optional readback, ack.
module led_pio_arbiter
  import led_pio_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int VERIFY = 1,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic                    busy,
  output logic [IDX_W-1:0]        owner,
  output logic [1:0]              pio_address,
  output logic                    pio_chipselect,
  output logic                    pio_write_n,
  output logic [DATA_W-1:0]       pio_writedata,
  input  logic [DATA_W-1:0]       pio_readdata
);

  state_t            r_state, w_nextState;
  logic [IDX_W-1:0]  r_owner, r_last, w_pickIdx;
  logic              w_pickValid;
  logic [DATA_W-1:0] r_heldData;
  logic [N_REQ-1:0]  r_ack, w_ack;
  logic              r_err, w_err, r_busy, r_cs, w_cs, r_wn, w_wn;

  led_pio_arbiter_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_valid (w_pickValid),
    .o_idx   (w_pickIdx)
  );

  // Outputs are computed for the state being entered and registered, so the
  // strobes, ack and err line up with the state they belong to.
  always_comb begin
    w_nextState = r_state;
    w_ack       = '0;
    w_err       = 1'b0;
    w_cs        = 1'b0;
    w_wn        = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_pickValid) begin
          w_nextState = WRITE;
          w_cs        = 1'b1;
          w_wn        = 1'b0;
        end
      end
      WRITE: begin
        if (VERIFY != 0) begin
          w_nextState = READ;
          w_cs        = 1'b1;
        end else begin
          w_nextState    = DONE;
          w_ack[r_owner] = 1'b1;
        end
      end
      READ: begin
        w_nextState    = DONE;
        w_ack[r_owner] = 1'b1;
        w_err          = (pio_readdata != r_heldData);
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_busy  <= (w_nextState != IDLE);
      r_cs    <= w_cs;
      r_wn    <= w_wn;
    end
  end

  // Owner and data are captured at grant; the pointer advances only on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= '0;
      r_last     <= IDX_W'(N_REQ - 1);
      r_heldData <= '0;
    end else begin
      if (r_state == IDLE && w_pickValid) begin
        r_owner    <= w_pickIdx;
        r_heldData <= req_data[w_pickIdx*DATA_W +: DATA_W];
      end
      if (r_state == DONE) r_last <= r_owner;
    end
  end

  assign ack            = r_ack;
  assign err            = r_err;
  assign busy           = r_busy;
  assign owner          = r_owner;
  assign pio_address    = DATA_REG;
  assign pio_chipselect = r_cs;
  assign pio_write_n    = r_wn;
  assign pio_writedata  = r_heldData;

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed and random traffic.
module tb_led_pio_arbiter;

  localparam int N = 4;

  logic        clk, reset;
  logic [3:0]  req, ack;
  logic [31:0] req_data;
  logic        err, busy, pio_chipselect, pio_write_n;
  logic [1:0]  owner, pio_address;
  logic [7:0]  pio_writedata, pio_readdata;

  logic [3:0]  req0, ack0;
  logic [31:0] data0;
  logic        err0, busy0, cs0, wn0;
  logic [1:0]  owner0, addr0;
  logic [7:0]  wdata0;

  logic [7:0]  pioReg;
  logic        fault, chkEn;
  int          nCompared, nMismatched;

  led_pio_arbiter #(.N_REQ(4), .DATA_W(8), .VERIFY(1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .busy(busy), .owner(owner), .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata), .pio_readdata(pio_readdata)
  );

  led_pio_arbiter #(.N_REQ(4), .DATA_W(8), .VERIFY(0)) u_dutNoVerify (
    .clk(clk), .reset(reset), .req(req0), .req_data(data0), .ack(ack0), .err(err0),
    .busy(busy0), .owner(owner0), .pio_address(addr0), .pio_chipselect(cs0),
    .pio_write_n(wn0), .pio_writedata(wdata0), .pio_readdata(8'h00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO slave: data register written on a strobed write, readback optionally corrupted.
  always @(posedge clk or posedge reset) begin
    if (reset) pioReg <= 8'h00;
    else if (pio_chipselect && !pio_write_n && pio_address == 2'd0) pioReg <= pio_writedata;
  end
  assign pio_readdata = fault ? 8'h00 : pioReg;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int pickNext(input logic [3:0] r, input int lastIdx);
    for (int o = 1; o <= N; o++)
      if (r[(lastIdx + o) % N]) return (lastIdx + o) % N;
    return -1;
  endfunction

  // Reference model: a transaction granted at edge g writes during cycle g+1,
  // reads during g+2, acks during g+3 and frees the arbiter at edge g+3.
  int         edgeN = 0, gEdge = 0, mOwner = 0, mLast = N - 1;
  bit         active = 0;
  logic [7:0] mData = 8'h00;
  logic [3:0] eAck = 4'h0;
  logic       eErr = 0, eCs = 0, eWn = 1, eBusy = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      active = 0; mOwner = 0; mLast = N - 1; mData = 8'h00;
      eAck = 4'h0; eErr = 0; eCs = 0; eWn = 1; eBusy = 0;
    end else begin
      bit finished;
      int d;
      finished = 0;
      edgeN++;
      eAck = 4'h0; eErr = 0; eCs = 0; eWn = 1;
      if (active && edgeN - gEdge == 3) begin
        active = 0; mLast = mOwner; finished = 1;
      end
      if (!active && !finished && req != 4'h0) begin
        mOwner = pickNext(req, mLast);
        mData  = req_data[mOwner*8 +: 8];
        active = 1;
        gEdge  = edgeN;
      end
      if (active) begin
        d = edgeN - gEdge;
        if (d == 0) begin eCs = 1; eWn = 0; end
        else if (d == 1) eCs = 1;
        else if (d == 2) begin
          eAck = 4'(1 << mOwner);
          eErr = fault && (mData != 8'h00);
        end
      end
      eBusy = active;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("ack", 32'(ack), 32'(eAck));
      checkOutput("err", 32'(err), 32'(eErr));
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("owner", 32'(owner), 32'(mOwner));
      checkOutput("chipselect", 32'(pio_chipselect), 32'(eCs));
      checkOutput("write_n", 32'(pio_write_n), 32'(eWn));
      checkOutput("address", 32'(pio_address), 32'd0);
      checkOutput("writedata", 32'(pio_writedata), 32'(mData));
    end
  end

  // Caller sits on a negedge; inputs are held for n cycles.
  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic f, input int n);
    req = r; req_data = d; fault = f;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    nCompared = 0; nMismatched = 0; chkEn = 0;
    reset = 1; req = 0; req_data = 0; fault = 0; req0 = 0; data0 = 0;
    repeat (2) @(negedge clk);
    checkOutput("rstAck", 32'(ack), 32'd0);
    checkOutput("rstWriteN", 32'(pio_write_n), 32'd1);
    checkOutput("rstOwner", 32'(owner), 32'd0);
    chkEn = 1;
    reset = 0;
    @(negedge clk);

    // Single request, then four-way contention
    applyStimulus(4'b0001, 32'h000000A5, 0, 3);
    applyStimulus(4'b0000, 32'h0, 0, 3);
    applyStimulus(4'b1111, 32'h44332211, 0, 20);
    applyStimulus(4'b0000, 32'h0, 0, 4);

    // Fairness after requester 2 was last served
    applyStimulus(4'b0100, 32'h00990000, 0, 3);
    applyStimulus(4'b0000, 32'h0, 0, 2);
    applyStimulus(4'b0101, 32'h00660055, 0, 8);
    applyStimulus(4'b0000, 32'h0, 0, 4);

    // Readback fault, then a clean transaction
    applyStimulus(4'b0001, 32'h0000003C, 1, 3);
    applyStimulus(4'b0000, 32'h0, 0, 2);
    applyStimulus(4'b0010, 32'h00005A00, 0, 3);
    applyStimulus(4'b0000, 32'h0, 0, 3);

    // Reset during WRITE, then a pending request after release
    req = 4'b0001; req_data = 32'h00000077;
    @(posedge clk);
    #2 reset = 1;
    #1;
    checkOutput("rstAsyncCs", 32'(pio_chipselect), 32'd0);
    checkOutput("rstAsyncWn", 32'(pio_write_n), 32'd1);
    @(negedge clk);
    req = 4'b0010; req_data = 32'h0000C300;
    reset = 0;
    applyStimulus(4'b0010, 32'h0000C300, 0, 3);
    applyStimulus(4'b0000, 32'h0, 0, 3);

    // No-readback build: write in cycle 1, ack in cycle 2
    req0 = 4'b0100; data0 = 32'h00FF0000;
    @(negedge clk);
    checkOutput("nv_writeN", 32'(wn0), 32'd0);
    checkOutput("nv_wdata", 32'(wdata0), 32'hFF);
    checkOutput("nv_ackEarly", 32'(ack0), 32'd0);
    @(negedge clk);
    req0 = 4'b0000;
    checkOutput("nv_ack", 32'(ack0), 32'b0100);
    checkOutput("nv_err", 32'(err0), 32'd0);
    checkOutput("nv_cs", 32'(cs0), 32'd0);
    @(negedge clk);
    checkOutput("nv_ackDone", 32'(ack0), 32'd0);
    checkOutput("nv_busy", 32'(busy0), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0), 1);
    applyStimulus(4'b0000, 32'h0, 0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
